// File: rtl/lvds_serdes_pkg.sv
// Shared definitions for the LVDS serializer/deserializer pair:
// word width, link state encoding and default alignment/idle patterns.
package lvds_serdes_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 5;

   localparam logic [WORD_W-1:0] DEF_SYNC_WORD = 32'hA5C3_3C5A;
   localparam logic [WORD_W-1:0] DEF_IDLE_WORD = 32'h5555_5555;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } link_state_e;

   // True on the last bit of a word, where the next word gets loaded.
   function automatic logic is_word_end(input logic [CNT_W-1:0] cnt);
      return cnt == CNT_W'(WORD_W - 1);
   endfunction

endpackage

// File: rtl/piso_shreg_32.sv
// 32-bit parallel-in serial-out register: load has priority over shift,
// shifting moves towards the MSB and fills with zero; bit 31 is the output.
module piso_shreg_32
   import lvds_serdes_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] load_data_i,
   input  logic              shift_i,
   output logic              msb_o
);

   logic [WORD_W-1:0] shreg_q;

   // Parallel load or shift left; cleared asynchronously so the line drops at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q <= '0;
      end else if (load_i) begin
         shreg_q <= load_data_i;
      end else if (shift_i) begin
         shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
      end
   end

   assign msb_o = shreg_q[WORD_W-1];

endmodule

// File: rtl/lvds_tx_serializer.sv
// LVDS transmit serializer. After reset (and on request) a burst of
// SYNC_COUNT alignment words is sent, then one payload word per 32 clocks,
// MSB first, with IDLE_WORD filling any slot that has no valid input.
//
// Handshake: ready_o is combinational and only high on the last bit of a
// word when the next slot is a payload slot; a word is taken when
// valid_i && ready_o at that rising edge. valid_i is ignored at all other
// times, and data_i need not be held after the transfer.
module lvds_tx_serializer
   import lvds_serdes_pkg::*;
#(
   parameter logic [WORD_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
   parameter int                SYNC_COUNT = 4,
   parameter logic [WORD_W-1:0] IDLE_WORD  = DEF_IDLE_WORD
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              resync_i,
   output logic              serial_o,
   output logic              sync_active_o,
   output logic              underrun_o,
   output logic [1:0]        state_o
);

   localparam logic [7:0] SYNC_COUNT_C = 8'(SYNC_COUNT);

   link_state_e       state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [7:0]        sync_cnt_q, sync_cnt_d;
   logic              word_end;
   logic              load;
   logic              load_is_sync;
   logic              load_is_idle;
   logic [WORD_W-1:0] load_word;
   logic [WORD_W-1:0] data_word;

   assign word_end  = is_word_end(bit_cnt_q);
   assign data_word = valid_i ? data_i : IDLE_WORD;

   // Link state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, word-boundary load selection and handshake.
   always_comb begin
      state_d      = state_q;
      sync_cnt_d   = sync_cnt_q;
      load         = 1'b0;
      load_is_sync = 1'b0;
      load_is_idle = 1'b0;
      load_word    = '0;
      ready_o      = 1'b0;
      case (state_q)
         ST_INIT: begin
            load         = 1'b1;
            load_is_sync = 1'b1;
            load_word    = SYNC_WORD;
            sync_cnt_d   = 8'd1;
            state_d      = ST_SYNC;
         end
         ST_SYNC: begin
            if (word_end) begin
               load = 1'b1;
               if (sync_cnt_q < SYNC_COUNT_C) begin
                  load_is_sync = 1'b1;
                  load_word    = SYNC_WORD;
                  sync_cnt_d   = sync_cnt_q + 8'd1;
               end else begin
                  // Burst complete: this boundary is already the first payload slot.
                  ready_o      = 1'b1;
                  load_word    = data_word;
                  load_is_idle = !valid_i;
                  state_d      = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_end) begin
               load = 1'b1;
               if (resync_i) begin
                  load_is_sync = 1'b1;
                  load_word    = SYNC_WORD;
                  sync_cnt_d   = 8'd1;
                  state_d      = ST_SYNC;
               end else begin
                  ready_o      = 1'b1;
                  load_word    = data_word;
                  load_is_idle = !valid_i;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Bit position within the current word; restarts at every load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
      end else if (load) begin
         bit_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 1'b1;
      end
   end

   // Sync burst word counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_cnt_q <= '0;
      end else begin
         sync_cnt_q <= sync_cnt_d;
      end
   end

   // Word-type flags aligned with the bits that appear on serial_o.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_active_o <= 1'b0;
         underrun_o    <= 1'b0;
      end else begin
         underrun_o <= load_is_idle;
         if (load) begin
            sync_active_o <= load_is_sync;
         end
      end
   end

   piso_shreg_32 u_shreg (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load),
      .load_data_i (load_word),
      .shift_i     (!load),
      .msb_o       (serial_o)
   );

   assign state_o = state_q;

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Bench for lvds_tx_serializer: a bit-queue model of the line predicts every
// output cycle by cycle, and a loopback receiver aligned on the sync burst
// returns payload words to a scoreboard of accepted words.
module tb_lvds_tx_serializer;

   localparam logic [31:0] SYNC_W  = 32'hA5C3_3C5A;
   localparam logic [31:0] IDLE_W  = 32'h5555_5555;
   localparam int          SYNC_N  = 4;

   logic        clk;
   logic        reset;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic        resync_i;
   logic        serial_o;
   logic        sync_active_o;
   logic        underrun_o;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad   = 0;

   lvds_tx_serializer #(
      .SYNC_WORD  (SYNC_W),
      .SYNC_COUNT (SYNC_N),
      .IDLE_WORD  (IDLE_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_i        (data_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .resync_i      (resync_i),
      .serial_o      (serial_o),
      .sync_active_o (sync_active_o),
      .underrun_o    (underrun_o),
      .state_o       (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- line model + scoreboard ----------------
   typedef struct packed {
      logic ser;
      logic syn;
      logic und;
   } line_bit_t;

   line_bit_t   mq[$];          // bits still to appear on the line, head = now
   logic [31:0] exp_q[$];       // accepted payload words awaiting loopback
   int          sync_left;
   int          cyc;
   int          first_ready_cyc;
   int          acc_cnt = 0;
   int          last_xfer_cyc;
   int          prev_xfer_cyc;
   int          n_resync = 0;
   int          resync_cyc;
   logic        exp_rdy;

   logic        rx_ok;
   logic        prev_sync;
   int          rx_cnt;
   logic [31:0] rx_word;
   logic        rx_is_sync;
   logic        rx_is_idle;
   logic        got_first_sync;
   logic [31:0] first_sync_word;

   task automatic push_word(input logic [31:0] w, input logic s, input logic u);
      line_bit_t b;
      for (int i = 31; i >= 0; i--) begin
         b.ser = w[i];
         b.syn = s;
         b.und = u && (i == 31);
         mq.push_back(b);
      end
   endtask

   initial begin
      first_ready_cyc = -1;
      got_first_sync  = 1'b0;
      rx_ok           = 1'b0;
      prev_sync       = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("rst_serial", 32'(serial_o), 32'd0);
            chk("rst_sync_active", 32'(sync_active_o), 32'd0);
            chk("rst_underrun", 32'(underrun_o), 32'd0);
            chk("rst_ready", 32'(ready_o), 32'd0);
            mq.delete();
            exp_q.delete();
            first_ready_cyc = -1;
            got_first_sync  = 1'b0;
            rx_ok           = 1'b0;
            prev_sync       = 1'b0;
         end else if (mq.size() == 0) begin
            // First cycle out of reset: nothing loaded yet.
            chk("init_serial", 32'(serial_o), 32'd0);
            chk("init_sync_active", 32'(sync_active_o), 32'd0);
            chk("init_ready", 32'(ready_o), 32'd0);
            push_word(SYNC_W, 1'b1, 1'b0);
            sync_left = SYNC_N - 1;
            cyc       = 0;
         end else begin
            cyc++;
            // Last bit of a word: payload slot unless more sync words are owed,
            // or a resync is requested at the end of a payload word.
            exp_rdy = (mq.size() == 1) && (sync_left == 0) && (mq[0].syn || !resync_i);
            chk("serial", 32'(serial_o), 32'(mq[0].ser));
            chk("sync_active", 32'(sync_active_o), 32'(mq[0].syn));
            chk("underrun", 32'(underrun_o), 32'(mq[0].und));
            chk("ready", 32'(ready_o), 32'(exp_rdy));
            if (exp_rdy && first_ready_cyc < 0) first_ready_cyc = cyc;
            if (mq.size() == 1) begin
               if (sync_left > 0) begin
                  push_word(SYNC_W, 1'b1, 1'b0);
                  sync_left--;
               end else if (!mq[0].syn && resync_i) begin
                  push_word(SYNC_W, 1'b1, 1'b0);
                  sync_left  = SYNC_N - 1;
                  resync_cyc = cyc;
                  n_resync++;
               end else if (valid_i) begin
                  push_word(data_i, 1'b0, 1'b0);
                  exp_q.push_back(data_i);
                  prev_xfer_cyc = last_xfer_cyc;
                  last_xfer_cyc = cyc;
                  acc_cnt++;
               end else begin
                  push_word(IDLE_W, 1'b0, 1'b1);
               end
            end
            void'(mq.pop_front());

            // Loopback receiver, aligned on the rising edge of sync_active_o.
            if (sync_active_o && !prev_sync) begin
               rx_ok  = 1'b1;
               rx_cnt = 0;
            end
            if (rx_ok) begin
               if (rx_cnt == 0) begin
                  rx_is_sync = sync_active_o;
                  rx_is_idle = underrun_o;
               end
               rx_word = {rx_word[30:0], serial_o};
               rx_cnt++;
               if (rx_cnt == 32) begin
                  rx_cnt = 0;
                  if (rx_is_sync) begin
                     if (!got_first_sync) begin
                        first_sync_word = rx_word;
                        got_first_sync  = 1'b1;
                     end
                  end else if (!rx_is_idle) begin
                     chk("rx_word_expected", 32'(exp_q.size() != 0), 32'd1);
                     if (exp_q.size() != 0) chk("rx_word", rx_word, exp_q.pop_front());
                  end
               end
            end
            prev_sync = sync_active_o;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      int start;
      start   = acc_cnt;
      valid_i = 1'b1;
      data_i  = w;
      for (int i = 0; i < 400 && acc_cnt == start; i++) tick(1);
      chk("send_accepted", 32'(acc_cnt != start), 32'd1);
      valid_i = 1'b0;
      data_i  = $urandom();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n0;
      reset    = 1'b0;
      valid_i  = 1'b0;
      resync_i = 1'b0;
      data_i   = '0;
      tick(4);
      reset = 1'b1;

      // Idle link: sync burst, then idle words with underrun pulses.
      tick(128 + 3 * 32);
      chk("first_ready_cycle", 32'(first_ready_cyc), 32'd128);
      chk("first_sync_word", first_sync_word, 32'hA5C3_3C5A);

      // Back-to-back payload words, one slot apart.
      send(32'h0000_0001);
      send(32'h8000_0000);
      chk("b2b_spacing", 32'(last_xfer_cyc - prev_xfer_cyc), 32'd32);

      // Loopback words, and a payload identical to the sync pattern.
      send(32'hDEAD_BEEF);
      send(32'h1234_5678);
      send(32'hA5C3_3C5A);

      // Resync requested with a word pending: burst first, then the word.
      n0       = n_resync;
      resync_i = 1'b1;
      valid_i  = 1'b1;
      data_i   = 32'hCAFE_F00D;
      for (int i = 0; i < 100 && n_resync == n0; i++) tick(1);
      chk("resync_seen", 32'(n_resync != n0), 32'd1);
      resync_i = 1'b0;
      send(32'hCAFE_F00D);
      chk("resync_ready_gap", 32'(last_xfer_cyc - resync_cyc), 32'd128);

      // Random traffic: valid, data and resync change freely every cycle.
      for (int c = 0; c < 3000; c++) begin
         valid_i  = ($urandom_range(0, 2) != 0);
         data_i   = $urandom();
         resync_i = ($urandom_range(0, 39) == 0);
         tick(1);
      end
      valid_i  = 1'b0;
      resync_i = 1'b0;
      tick(200);

      // Reset in the middle of an all-ones word.
      send(32'hFFFF_FFFF);
      tick(17);
      chk("pre_abort_serial", 32'(serial_o), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_serial", 32'(serial_o), 32'd0);
      chk("abort_sync_active", 32'(sync_active_o), 32'd0);
      tick(3);
      reset = 1'b1;
      tick(160);
      chk("restart_first_ready", 32'(first_ready_cyc), 32'd128);
      chk("restart_sync_word", first_sync_word, 32'hA5C3_3C5A);

      send(32'h0F0F_1E1E);
      tick(100);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lvds_tx_serializer.md
LVDS_TX_SERIALIZER -- requirements
Module: lvds_tx_serializer

Interface
REQ-001 Parameter SYNC_WORD, 32'hA5C3_3C5A, alignment pattern sent after reset and on resync.
REQ-002 Parameter SYNC_COUNT, 4, consecutive SYNC_WORD repetitions per sync burst; legal range 1..255.
REQ-003 Parameter IDLE_WORD, 32'h5555_5555, word sent in a DATA slot with no valid input.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 data_i  in  32  parallel word to transmit, MSB first.
REQ-007 valid_i  in  1  data_i holds a word to send.
REQ-008 ready_o  out  1  block accepts data_i this cycle; transfer = valid_i && ready_o.
REQ-009 resync_i  in  1  request a new sync burst at the next word boundary.
REQ-010 serial_o  out  1  serial bit stream, registered, one bit per clk.
REQ-011 sync_active_o  out  1  high while a SYNC_WORD is on serial_o.
REQ-012 underrun_o  out  1  one-cycle pulse when IDLE_WORD is loaded in DATA state.

Function
REQ-013 The block SHALL hold a 32-bit shift register; serial_o is its bit 31, so the MSB of each loaded word appears on serial_o in the cycle after the load.
REQ-014 A 5-bit bit_cnt SHALL count 0..31 and wrap; when bit_cnt != 31 the register shifts left by one, filling 0.
REQ-015 States SHALL be INIT, SYNC and DATA.
REQ-016 INIT: lasts one cycle; loads SYNC_WORD, sets bit_cnt=0 and sync_cnt=1, and goes to SYNC.
REQ-017 SYNC, bit_cnt==31, sync_cnt<SYNC_COUNT: reload SYNC_WORD and increment sync_cnt.
REQ-018 SYNC, bit_cnt==31, sync_cnt==SYNC_COUNT: go to DATA and perform a DATA load per REQ-020.
REQ-019 ready_o SHALL be combinational and high exactly at a load boundary that enters or stays in DATA: (SYNC && bit_cnt==31 && sync_cnt==SYNC_COUNT) or (DATA && bit_cnt==31 && !resync_i).
REQ-020 DATA load: if valid_i, load data_i; otherwise load IDLE_WORD and pulse underrun_o in the following cycle.
REQ-021 DATA, bit_cnt==31, resync_i=1: load SYNC_WORD, set sync_cnt=1, go to SYNC, and keep ready_o low.
REQ-022 resync_i SHALL be sampled only at bit_cnt==31; it has no effect at other times or in SYNC.
REQ-023 valid_i outside a ready_o cycle SHALL be ignored; data_i need not be held after a transfer.
REQ-024 Payload equal to SYNC_WORD SHALL be sent unmodified; no escaping is performed.
REQ-025 Steady-state throughput SHALL be one word per 32 cycles with no gap bits between words.
REQ-026 sync_active_o SHALL be registered and high for every cycle in which serial_o carries a SYNC_WORD bit.

Reset
REQ-027 While reset=0: state=INIT, shift register=0, serial_o=0, bit_cnt=0, sync_cnt=0, sync_active_o=0, underrun_o=0, ready_o=0.
REQ-028 Reset asserted mid-word SHALL abort the word immediately; after release, transmission restarts with a full sync burst.

Structure
REQ-029 Shared package lvds_serdes_pkg SHALL hold WORD_W=32, the state encoding, and the default SYNC_WORD and IDLE_WORD values, shared with the receive deserializer.
REQ-030 One sub-module, piso_shreg_32 (32-bit parallel-load, shift-left register exposing bit 31), SHALL be instantiated; the FSM, counters and handshake stay in the top level.

Verification
REQ-031 Release reset, valid_i=0 -> serial_o carries 4x 32'hA5C3_3C5A from cycle 1; ready_o first high in cycle 128; IDLE_WORD follows; underrun_o pulses once per idle word.
REQ-032 valid_i held high with 32'h0000_0001 then 32'h8000_0000 -> both accepted 32 cycles apart; serial bit stream reproduces them MSB first, no gaps.
REQ-033 Loopback into the 32-bit deserializer, aligned at the sync burst -> received words equal sent words 32'hDEAD_BEEF and 32'h1234_5678.
REQ-034 resync_i=1 at a DATA boundary with valid_i=1 -> no transfer; 4 sync words sent; ready_o reasserts 128 cycles later; held word then accepted.
REQ-035 Assert reset at bit_cnt=17 of 32'hFFFF_FFFF -> serial_o=0 immediately; after release, INIT and a full sync burst precede any data.
REQ-036 Send data_i=32'hA5C3_3C5A in DATA -> transmitted verbatim, sync_active_o stays 0.
